// File: rtl/ray_tri_scheduler.sv
// ray_tri_scheduler: walks triangles 0..N-1 for one ray, issues each pair to the intersection
// unit and returns the closest valid hit. Optional watchdog on WAIT: define RTS_WATCHDOG_EN.
`timescale 1ns/1ps
module ray_tri_scheduler #(
  parameter int                 TRI_IDX_W   = 16,
  parameter logic signed [31:0] MAX_T       = 32'sh7FFFFFFF,
  parameter int                 INV_CNT_W   = 8,
  parameter int                 TIMEOUT_CYC = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ray_valid,
  output logic                  o_ray_ready,
  input  logic [0:1][0:2][31:0] i_ray,
  input  logic [TRI_IDX_W-1:0]  i_num_tri,
  output logic                  o_tri_rd,
  output logic [TRI_IDX_W-1:0]  o_tri_addr,
  input  logic [0:2][0:2][31:0] i_tri_data,
  output logic                  o_isect_valid,
  output logic [0:2][0:2][31:0] o_isect_triangle,
  output logic [0:1][0:2][31:0] o_isect_ray,
  input  logic                  i_isect_valid,
  input  logic                  i_isect_hit,
  input  logic                  i_isect_invalid,
  input  logic [31:0]           i_isect_t,
  input  logic [0:2][31:0]      i_isect_normal,
  output logic                  o_hit_valid,
  input  logic                  i_hit_ready,
  output logic                  o_hit,
  output logic [TRI_IDX_W-1:0]  o_hit_idx,
  output logic [31:0]           o_hit_t,
  output logic [0:2][31:0]      o_hit_normal,
  output logic [INV_CNT_W-1:0]  o_inv_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  function automatic logic [INV_CNT_W-1:0] sat_inc(input logic [INV_CNT_W-1:0] v);
    if (v == {INV_CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + INV_CNT_W'(1);
    end
  endfunction

  function automatic logic is_closer(input logic [31:0] t, input logic [31:0] best);
    is_closer = ($signed(t) < $signed(best));
  endfunction

  state_e                 state_q, state_d;
  logic [0:1][0:2][31:0]  ray_q, ray_d;
  logic [TRI_IDX_W-1:0]   num_tri_q, num_tri_d;
  logic [TRI_IDX_W-1:0]   idx_q, idx_d;
  logic [0:2][0:2][31:0]  tri_q, tri_d;
  logic                   ray_ready_q, ray_ready_d;
  logic                   tri_rd_q, tri_rd_d;
  logic                   isect_valid_q, isect_valid_d;
  logic                   hit_valid_q, hit_valid_d;
  logic                   hit_q, hit_d;
  logic [TRI_IDX_W-1:0]   hit_idx_q, hit_idx_d;
  logic [31:0]            hit_t_q, hit_t_d;
  logic [0:2][31:0]       hit_normal_q, hit_normal_d;
  logic [INV_CNT_W-1:0]   inv_cnt_q, inv_cnt_d;

  logic timeout_s;
  logic take_s;
  logic bad_s;
  logic last_s;

`ifdef RTS_WATCHDOG_EN
  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  assign timeout_s = (state_q == S_WAIT) && (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1));
`else
  logic [31:0] wd_unused_s;
  assign wd_unused_s = 32'(TIMEOUT_CYC);
  assign timeout_s   = 1'b0;
`endif

  // A response on the timeout cycle wins, so a timeout counts as invalid only without one.
  assign take_s = i_isect_valid || timeout_s;
  assign bad_s  = !i_isect_valid || i_isect_invalid;
  assign last_s = (idx_q == (num_tri_q - TRI_IDX_W'(1)));

  // Next-state and datapath updates for the job sequencer.
  always_comb begin
    state_d      = state_q;
    ray_d        = ray_q;
    num_tri_d    = num_tri_q;
    idx_d        = idx_q;
    tri_d        = tri_q;
    hit_d        = hit_q;
    hit_idx_d    = hit_idx_q;
    hit_t_d      = hit_t_q;
    hit_normal_d = hit_normal_q;
    inv_cnt_d    = inv_cnt_q;
`ifdef RTS_WATCHDOG_EN
    wd_cnt_d     = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_ray_valid && ray_ready_q) begin
          ray_d        = i_ray;
          num_tri_d    = i_num_tri;
          idx_d        = '0;
          hit_d        = 1'b0;
          hit_idx_d    = '0;
          hit_t_d      = MAX_T;
          hit_normal_d = '0;
          inv_cnt_d    = '0;
          state_d      = (i_num_tri != '0) ? S_FETCH : S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        tri_d   = i_tri_data;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (take_s) begin
          if (bad_s) begin
            inv_cnt_d = sat_inc(inv_cnt_q);
          end else if (i_isect_hit && is_closer(i_isect_t, hit_t_q)) begin
            hit_d        = 1'b1;
            hit_idx_d    = idx_q;
            hit_t_d      = i_isect_t;
            hit_normal_d = i_isect_normal;
          end else begin
            hit_d = hit_q;
          end
          if (last_s) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + TRI_IDX_W'(1);
            state_d = S_FETCH;
          end
        end else begin
`ifdef RTS_WATCHDOG_EN
          wd_cnt_d = wd_cnt_q + WD_W'(1);
`endif
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        if (hit_valid_q && i_hit_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Strobes are registered from the state being entered; o_hit_valid trails DONE entry by one cycle.
    ray_ready_d   = (state_d == S_IDLE);
    tri_rd_d      = (state_d == S_FETCH);
    isect_valid_d = (state_d == S_ISSUE);
    hit_valid_d   = (state_q == S_DONE) && (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      ray_q         <= '0;
      num_tri_q     <= '0;
      idx_q         <= '0;
      tri_q         <= '0;
      ray_ready_q   <= 1'b1;
      tri_rd_q      <= 1'b0;
      isect_valid_q <= 1'b0;
      hit_valid_q   <= 1'b0;
      hit_q         <= 1'b0;
      hit_idx_q     <= '0;
      hit_t_q       <= MAX_T;
      hit_normal_q  <= '0;
      inv_cnt_q     <= '0;
`ifdef RTS_WATCHDOG_EN
      wd_cnt_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      ray_q         <= ray_d;
      num_tri_q     <= num_tri_d;
      idx_q         <= idx_d;
      tri_q         <= tri_d;
      ray_ready_q   <= ray_ready_d;
      tri_rd_q      <= tri_rd_d;
      isect_valid_q <= isect_valid_d;
      hit_valid_q   <= hit_valid_d;
      hit_q         <= hit_d;
      hit_idx_q     <= hit_idx_d;
      hit_t_q       <= hit_t_d;
      hit_normal_q  <= hit_normal_d;
      inv_cnt_q     <= inv_cnt_d;
`ifdef RTS_WATCHDOG_EN
      wd_cnt_q      <= wd_cnt_d;
`endif
    end
  end

  assign o_ray_ready      = ray_ready_q;
  assign o_tri_rd         = tri_rd_q;
  assign o_tri_addr       = idx_q;
  assign o_isect_valid    = isect_valid_q;
  assign o_isect_triangle = tri_q;
  assign o_isect_ray      = ray_q;
  assign o_hit_valid      = hit_valid_q;
  assign o_hit            = hit_q;
  assign o_hit_idx        = hit_idx_q;
  assign o_hit_t          = hit_t_q;
  assign o_hit_normal     = hit_normal_q;
  assign o_inv_cnt        = inv_cnt_q;

endmodule

// File: tb/tb_ray_tri_scheduler.sv
// Bench for ray_tri_scheduler: table of jobs driven through a triangle-memory and
// intersection-unit responder, results checked against a scoreboard queue.
`timescale 1ns/1ps
module tb_ray_tri_scheduler;

  localparam logic [31:0] MAXT = 32'h7FFFFFFF;

  logic                  clk;
  logic                  i_rst;
  logic                  i_ray_valid;
  logic                  o_ray_ready;
  logic [0:1][0:2][31:0] i_ray;
  logic [15:0]           i_num_tri;
  logic                  o_tri_rd;
  logic [15:0]           o_tri_addr;
  logic [0:2][0:2][31:0] i_tri_data;
  logic                  o_isect_valid;
  logic [0:2][0:2][31:0] o_isect_triangle;
  logic [0:1][0:2][31:0] o_isect_ray;
  logic                  i_isect_valid;
  logic                  i_isect_hit;
  logic                  i_isect_invalid;
  logic [31:0]           i_isect_t;
  logic [0:2][31:0]      i_isect_normal;
  logic                  o_hit_valid;
  logic                  i_hit_ready;
  logic                  o_hit;
  logic [15:0]           o_hit_idx;
  logic [31:0]           o_hit_t;
  logic [0:2][31:0]      o_hit_normal;
  logic [7:0]            o_inv_cnt;

  ray_tri_scheduler #(
    .TRI_IDX_W(16), .MAX_T(32'sh7FFFFFFF), .INV_CNT_W(8), .TIMEOUT_CYC(8)
  ) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_ray_valid(i_ray_valid), .o_ray_ready(o_ray_ready), .i_ray(i_ray), .i_num_tri(i_num_tri),
    .o_tri_rd(o_tri_rd), .o_tri_addr(o_tri_addr), .i_tri_data(i_tri_data),
    .o_isect_valid(o_isect_valid), .o_isect_triangle(o_isect_triangle), .o_isect_ray(o_isect_ray),
    .i_isect_valid(i_isect_valid), .i_isect_hit(i_isect_hit), .i_isect_invalid(i_isect_invalid),
    .i_isect_t(i_isect_t), .i_isect_normal(i_isect_normal),
    .o_hit_valid(o_hit_valid), .i_hit_ready(i_hit_ready), .o_hit(o_hit), .o_hit_idx(o_hit_idx),
    .o_hit_t(o_hit_t), .o_hit_normal(o_hit_normal), .o_inv_cnt(o_inv_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int rd_pulses = 0;
  int iv_pulses = 0;
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (o_tri_rd) rd_pulses = rd_pulses + 1;
    if (o_isect_valid) iv_pulses = iv_pulses + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [15:0]      n;
    logic [3:0]       hit_m;
    logic [3:0]       inv_m;
    logic [3:0]       nr_m;
    logic [3:0][31:0] t;
    logic [7:0]       dly;
    logic             e_hit;
    logic [15:0]      e_idx;
    logic [31:0]      e_t;
    logic [7:0]       e_inv;
  } vec_t;

  typedef struct packed {
    logic             hit;
    logic [15:0]      idx;
    logic [31:0]      t;
    logic [0:2][31:0] normal;
    logic [7:0]       inv;
    logic [31:0]      lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [0:1][0:2][31:0] ray_of(input int j);
    logic [0:1][0:2][31:0] r;
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 3; b++)
        r[a][b] = 32'h1000_0000 + 32'(j * 16 + a * 4 + b);
    return r;
  endfunction

  function automatic logic [0:2][0:2][31:0] tri_of(input int k);
    logic [0:2][0:2][31:0] r;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        r[i][j] = {16'(k), 8'(i), 8'(j)};
    return r;
  endfunction

  function automatic logic [0:2][31:0] nrm_of(input int k);
    logic [0:2][31:0] r;
    for (int i = 0; i < 3; i++) r[i] = 32'(3 * k + i + 1);
    return r;
  endfunction

  function automatic vec_t mk(input int n, input logic [3:0] hm, input logic [3:0] im,
                              input logic [3:0] nm, input logic [31:0] t0, input logic [31:0] t1,
                              input logic [31:0] t2, input logic [31:0] t3, input int dly,
                              input logic eh, input int eidx, input logic [31:0] et, input int einv);
    vec_t v;
    v.n = 16'(n); v.hit_m = hm; v.inv_m = im; v.nr_m = nm;
    v.t[0] = t0; v.t[1] = t1; v.t[2] = t2; v.t[3] = t3;
    v.dly = 8'(dly); v.e_hit = eh; v.e_idx = 16'(eidx); v.e_t = et; v.e_inv = 8'(einv);
    return v;
  endfunction

  task automatic idle_resp();
    i_isect_valid   = 1'b0;
    i_isect_hit     = 1'b1;
    i_isect_invalid = 1'b0;
    i_isect_t       = 32'h8000_0000;
    i_isect_normal  = {3{32'hFFFF_FFFF}};
  endtask

  // sel: 0 = o_tri_rd, 1 = o_hit_valid, 2 = o_ray_ready
  task automatic wait_out(input int sel, input int budget, input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i <= budget; i++) begin
      if ((sel == 0 && o_tri_rd) || (sel == 1 && o_hit_valid) || (sel == 2 && o_ray_ready)) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: still 0 after %0d cycles, required 1", name, budget);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ray_ready"}, 128'(o_ray_ready), 128'(1'b1));
    chk({tag, "_hit_valid"}, 128'(o_hit_valid), 128'(1'b0));
    chk({tag, "_tri_rd"}, 128'(o_tri_rd), 128'(1'b0));
    chk({tag, "_isect_valid"}, 128'(o_isect_valid), 128'(1'b0));
    chk({tag, "_hit"}, 128'(o_hit), 128'(1'b0));
    chk({tag, "_hit_t"}, 128'(o_hit_t), 128'(MAXT));
    chk({tag, "_hit_idx"}, 128'(o_hit_idx), 128'(0));
    chk({tag, "_normal"}, 128'(o_hit_normal), 128'(0));
    chk({tag, "_inv_cnt"}, 128'(o_inv_cnt), 128'(0));
    chk({tag, "_addr"}, 128'(o_tri_addr), 128'(0));
    chk({tag, "_isect_ray"}, 128'(o_isect_ray), 128'(0));
    chk({tag, "_isect_tri"}, 128'(o_isect_triangle), 128'(0));
  endtask

  task automatic run_job(input vec_t v, input int jid, input int hold);
    exp_t e;
    exp_t ex;
    bit ok;
    int hs, rd0, iv0, n;
    logic [0:1][0:2][31:0] r;
    n = int'(v.n);
    e.hit = v.e_hit; e.idx = v.e_idx; e.t = v.e_t; e.inv = v.e_inv;
    e.normal = v.e_hit ? nrm_of(int'(v.e_idx)) : '0;
    e.lat = 32'd1;
    for (int k = 0; k < n; k++) e.lat += (k < 4 && v.nr_m[k]) ? 32'd11 : 32'd4 + 32'(v.dly);
    sb.push_back(e);

    wait_out(2, 50, $sformatf("job%0d_ray_ready", jid), ok);
    r = ray_of(jid);
    i_ray = r; i_num_tri = v.n; i_ray_valid = 1'b1;
    rd0 = rd_pulses; iv0 = iv_pulses;
    step();
    hs = cyc;
    i_ray_valid = 1'b0;
    i_ray = ray_of(jid + 100);
    chk($sformatf("job%0d_ready_low", jid), 128'(o_ray_ready), 128'(1'b0));

    for (int k = 0; k < n; k++) begin
      wait_out(0, 30, $sformatf("job%0d_tri_rd%0d", jid, k), ok);
      if (!ok) begin
        void'(sb.pop_back());
        return;
      end
      chk($sformatf("job%0d_addr%0d", jid, k), 128'(o_tri_addr), 128'(16'(k)));
      step();
      i_tri_data = tri_of(k);
      step();
      i_tri_data = {9{32'hDEAD_BEEF}};
      chk($sformatf("job%0d_issue%0d", jid, k), 128'(o_isect_valid), 128'(1'b1));
      chk($sformatf("job%0d_tri%0d", jid, k), 128'(o_isect_triangle), 128'(tri_of(k)));
      chk($sformatf("job%0d_ray%0d", jid, k), 128'(o_isect_ray), 128'(r));
      if (!(k < 4 && v.nr_m[k])) begin
        step();
        repeat (int'(v.dly)) step();
        i_isect_valid   = 1'b1;
        i_isect_hit     = (k < 4) ? v.hit_m[k] : 1'b0;
        i_isect_invalid = (k < 4) ? v.inv_m[k] : 1'b1;
        i_isect_t       = (k < 4) ? v.t[k] : 32'h0;
        i_isect_normal  = nrm_of(k);
        step();
        idle_resp();
      end
    end

    wait_out(1, 30, $sformatf("job%0d_hit_valid", jid), ok);
    ex = sb.pop_front();
    if (!ok) return;
    chk($sformatf("job%0d_latency", jid), 128'(cyc - hs), 128'(ex.lat));
    chk($sformatf("job%0d_rd_pulses", jid), 128'(rd_pulses - rd0), 128'(n));
    chk($sformatf("job%0d_issue_pulses", jid), 128'(iv_pulses - iv0), 128'(n));
    chk($sformatf("job%0d_hit", jid), 128'(o_hit), 128'(ex.hit));
    chk($sformatf("job%0d_idx", jid), 128'(o_hit_idx), 128'(ex.idx));
    chk($sformatf("job%0d_t", jid), 128'(o_hit_t), 128'(ex.t));
    chk($sformatf("job%0d_normal", jid), 128'(o_hit_normal), 128'(ex.normal));
    chk($sformatf("job%0d_inv", jid), 128'(o_inv_cnt), 128'(ex.inv));

    for (int h = 0; h < hold; h++) begin
      i_ray_valid = 1'b1;
      i_ray = ray_of(jid + 200);
      step();
      chk($sformatf("job%0d_hold%0d_valid", jid, h), 128'(o_hit_valid), 128'(1'b1));
      chk($sformatf("job%0d_hold%0d_ready", jid, h), 128'(o_ray_ready), 128'(1'b0));
      chk($sformatf("job%0d_hold%0d_res", jid, h), {o_hit_t, o_hit_normal}, {ex.t, ex.normal});
    end
    i_ray_valid = 1'b0;
    i_hit_ready = 1'b1;
    step();
    i_hit_ready = 1'b0;
    chk($sformatf("job%0d_valid_drop", jid), 128'(o_hit_valid), 128'(1'b0));
    chk($sformatf("job%0d_ready_back", jid), 128'(o_ray_ready), 128'(1'b1));
    chk($sformatf("job%0d_ray_kept", jid), 128'(o_isect_ray), 128'(r));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    vecs[0] = mk(1, 4'b0001, 4'b0000, 4'b0000, 32'h0002_0000, 32'h0, 32'h0, 32'h0, 0, 1'b1, 0, 32'h0002_0000, 0);
    vecs[1] = mk(3, 4'b0011, 4'b0000, 4'b0000, 32'h0005_0000, 32'h0003_0000, 32'h0001_0000, 32'h0, 0, 1'b1, 1, 32'h0003_0000, 0);
    vecs[2] = mk(3, 4'b0111, 4'b0001, 4'b0000, 32'h0002_0000, 32'h0002_0000, 32'h0002_0000, 32'h0, 1, 1'b1, 1, 32'h0002_0000, 1);
    vecs[3] = mk(0, 4'b0000, 4'b0000, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1'b0, 0, MAXT, 0);
    vecs[4] = mk(4, 4'b1111, 4'b0100, 4'b0000, 32'h0001_0000, 32'hFFFF_8000, 32'hFFF0_0000, 32'hFFFF_8000, 2, 1'b1, 1, 32'hFFFF_8000, 1);
    vecs[5] = mk(2, 4'b0000, 4'b0000, 4'b0000, 32'h0000_0001, 32'h0000_0002, 32'h0, 32'h0, 1, 1'b0, 0, MAXT, 0);
    vecs[6] = mk(2, 4'b0011, 4'b0010, 4'b0000, MAXT, 32'h0, 32'h0, 32'h0, 3, 1'b0, 0, MAXT, 1);
    vecs[7] = mk(4, 4'b1111, 4'b0000, 4'b0000, 32'h0004_0000, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 0, 1'b1, 3, 32'h0001_0000, 0);
    vecs[8] = mk(1, 4'b0001, 4'b0000, 4'b0000, 32'h0005_0000, 32'h0, 32'h0, 32'h0, 7, 1'b1, 0, 32'h0005_0000, 0);

    i_rst = 1'b1; i_ray_valid = 1'b0; i_ray = '0; i_num_tri = '0;
    i_tri_data = {9{32'hDEAD_BEEF}}; i_hit_ready = 1'b0;
    idle_resp();
    repeat (3) step();
    chk_reset_vals("rst_held");
    i_rst = 1'b0;
    step();
    chk_reset_vals("rst_released");

    for (int i = 0; i < 9; i++) run_job(vecs[i], i, 0);

    // Result held under backpressure while a second ray is offered.
    run_job(vecs[0], 10, 10);

    // Invalid counter saturates; index runs past 8 bits.
    run_job(mk(300, 4'b0000, 4'b1111, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1'b0, 0, MAXT, 255), 11, 0);

    // Reset mid-job while in WAIT, then a stray response in IDLE.
    i_ray = ray_of(12); i_num_tri = 16'd2; i_ray_valid = 1'b1;
    step();
    i_ray_valid = 1'b0;
    wait_out(0, 10, "rst_job_tri_rd", ok);
    step();
    i_tri_data = tri_of(0);
    step();
    i_tri_data = {9{32'hDEAD_BEEF}};
    step();
    step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    chk_reset_vals("rst_wait");
    i_isect_valid = 1'b1; i_isect_hit = 1'b1; i_isect_invalid = 1'b1; i_isect_t = 32'h0000_0100;
    step();
    idle_resp();
    step();
    chk_reset_vals("stray_resp");
    run_job(vecs[1], 13, 0);

`ifdef RTS_WATCHDOG_EN
    // tri0 never answers: watchdog advances after 8 WAIT cycles as an invalid response.
    run_job(mk(2, 4'b0010, 4'b0000, 4'b0001, 32'h0, 32'h0001_0000, 32'h0, 32'h0, 0, 1'b1, 1, 32'h0001_0000, 1), 14, 0);
`else
    // No watchdog: a response 100 cycles late is still accepted.
    run_job(mk(1, 4'b0001, 4'b0000, 4'b0000, 32'h0003_0000, 32'h0, 32'h0, 32'h0, 100, 1'b1, 0, 32'h0003_0000, 0), 14, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ray_tri_scheduler.md
Name: ray_tri_scheduler

Overview:
- Issuing end of the ray/triangle intersection interface: accepts one ray, walks triangles 0..N-1 from triangle memory, and presents each (triangle, ray) pair to an intersection unit.
- Collects each hit/invalid/t/normal response and keeps the closest valid hit.
- Returns the closest hit to the ray source with a valid/ready handshake.
- Sits between the HPS-fed ray queue and the intersection datapath; all values are signed Q16.16 (1.0 = 32'sh00010000).

Parameters:
- TRI_IDX_W, 16, width of triangle index / count
- MAX_T, 32'sh7FFFFFFF, initial best t and value reported on miss
- INV_CNT_W, 8, width of saturating invalid-response counter
- TIMEOUT_CYC, 64, watchdog limit in WAIT cycles; used only with RTS_WATCHDOG_EN

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_ray_valid  in  1  ray offered
- o_ray_ready  out  1  high only in IDLE
- i_ray  in  [0:1][0:2][31:0]  [0]=origin E, [1]=direction D
- i_num_tri  in  TRI_IDX_W  triangle count N, captured with ray
- o_tri_rd  out  1  memory read strobe
- o_tri_addr  out  TRI_IDX_W  triangle index
- i_tri_data  in  [0:2][0:2][31:0]  triangle vertices, valid exactly 1 cycle after o_tri_rd
- o_isect_valid  out  1  one-cycle issue pulse
- o_isect_triangle  out  [0:2][0:2][31:0]  held from LOAD until next LOAD
- o_isect_ray  out  [0:1][0:2][31:0]  captured ray, held for whole job
- i_isect_valid  in  1  response strobe
- i_isect_hit  in  1  intersection result
- i_isect_invalid  in  1  overflow/div-by-0 flag
- i_isect_t  in  32  hit distance
- i_isect_normal  in  [0:2][31:0]  unnormalized normal
- o_hit_valid  out  1  result available
- i_hit_ready  in  1  result consumed
- o_hit  out  1  any valid hit found
- o_hit_idx  out  TRI_IDX_W  index of closest hit
- o_hit_t  out  32  closest t, MAX_T on miss
- o_hit_normal  out  [0:2][31:0]  normal of closest hit, 0 on miss
- o_inv_cnt  out  INV_CNT_W  invalid responses in this job, saturating

Behaviour:
- All outputs registered. On reset: state IDLE, o_ray_ready=1, all other outputs 0, o_hit_t=MAX_T.
- Reset at any point, including mid-job, aborts the job; the next state is IDLE.
- FSM states: IDLE, FETCH, LOAD, ISSUE, WAIT, DONE.
- IDLE:
  - Ray handshake occurs when i_ray_valid & o_ray_ready at a clock edge; capture the ray and N.
  - Clear best: t=MAX_T, hit=0, idx=0, normal=0, inv_cnt=0.
  - Next state is FETCH if N>0, else DONE.
- FETCH: o_tri_rd=1, o_tri_addr=current idx; next state LOAD.
- LOAD: capture i_tri_data into o_isect_triangle; next state ISSUE.
- ISSUE: o_isect_valid=1 for exactly one cycle; next state WAIT.
- WAIT: stay until i_isect_valid=1, then update and advance:
  - if i_isect_invalid: inv_cnt+1, saturating at all-ones; no best update;
  - else if i_isect_hit and signed i_isect_t < best t (strict; first of equal t wins): best t, idx, normal updated, hit=1;
  - idx == N-1 -> DONE, else idx+1 and FETCH.
- i_isect_valid is ignored outside WAIT.
- DONE:
  - o_hit_valid=1; result outputs hold stable until i_hit_ready=1.
  - On that edge: o_hit_valid drops, state IDLE, o_ray_ready=1 next cycle.
- Latency: with response in the first WAIT cycle, o_hit_valid rises 4N+1 cycles after the ray handshake edge (N=0 -> 1 cycle).
- Only one ray in flight; o_ray_ready=0 in every state except IDLE.
- Index counter never wraps: N up to 2^TRI_IDX_W-1 is supported.

Optional Feature:
- Macro RTS_WATCHDOG_EN.
- Defined: a counter runs in WAIT. After TIMEOUT_CYC cycles without i_isect_valid, the current triangle is treated as an invalid response (inv_cnt+1, advance normally). A response arriving on the timeout cycle itself takes priority over the timeout.
- Undefined: WAIT lasts indefinitely; TIMEOUT_CYC is unused.

Test Plan:
- N=1, response 1 cycle after issue hit=1 t=32'sh00020000 normal={1,2,3} -> o_hit_valid at handshake+5, o_hit=1, idx=0, t=32'sh00020000, normal={1,2,3}, inv_cnt=0.
- N=3, responses (hit,t) = (1,0x00050000),(1,0x00030000),(0,0x00010000) -> o_hit=1, idx=1, t=0x00030000; o_tri_addr sequence 0,1,2.
- N=3, all t=0x00020000 hit=1, tri0 invalid=1 -> idx=1, inv_cnt=1.
- N=0 -> o_hit_valid at handshake+1, o_hit=0, t=MAX_T, no o_tri_rd or o_isect_valid pulse.
- Backpressure and reset:
  - i_hit_ready=0 for 10 cycles in DONE -> outputs stable, o_ray_ready=0, new i_ray_valid ignored.
  - i_rst pulsed during WAIT -> next cycle IDLE, outputs at reset values; a stray i_isect_valid is ignored.
- RTS_WATCHDOG_EN, TIMEOUT_CYC=8, N=2, no response for tri0, tri1 hit t=0x00010000 -> tri0 advances after 8 WAIT cycles, inv_cnt=1, idx=1. Without the macro, the FSM stays in WAIT indefinitely.
